// File: rtl/usart_rx_deframer_if.sv
// CPU-side view of the USART receive holding buffer: read strobe plus
// buffered byte and its status flags.
interface usart_rx_deframer_if;
  logic       Rd;
  logic [7:0] RxData;
  logic       AV;
  logic       CP;
  logic       OV;
  logic       FE;
  logic       PE;

  modport master (output Rd, input RxData, AV, CP, OV, FE, PE);
  modport slave  (input Rd, output RxData, AV, CP, OV, FE, PE);
endinterface

// File: rtl/usart_rx_deframer.sv
// USART 8N1/8E1 receive deframer with a one-entry holding buffer.
// Optional USART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module usart_rx_deframer #(
  parameter int unsigned MIN_DIV = 4
) (
  input  logic                CPUClk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [11:0]         BitDiv,
  input  logic                ParEn,
  input  logic                SLBit,
  usart_rx_deframer_if.slave  cpu
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic [11:0] MIN_DIV_C = 12'(MIN_DIV);

  function automatic logic even_par_err(input logic [7:0] data, input logic p);
    return (^data) ^ p;
  endfunction

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic        armed_q, armed_d;
  logic [11:0] div_q, div_d;
  logic [11:0] cnt_q, cnt_d;
  logic        par_en_q, par_en_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d;
  logic        commit_s;
  logic        ferr_s;
  logic        bit_s;
  logic        tick_s;
  logic [11:0] div_sel_s;

  logic [7:0]  rx_data_q;
  logic        av_q, cp_q, ov_q, fe_q, pe_q;

`ifdef USART_RX_MAJORITY_EN
  // The vote uses samples t, t-1, t-2, so the decision lands one clock after
  // the nominal sample point; the start load compensates by one.
  localparam logic [11:0] START_OFS = 12'd0;
  logic hist1_q, hist2_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two-deep history of the synchronized line for the majority vote
  always_ff @(posedge CPUClk) begin
    if (Reset) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  assign bit_s = maj3(sync2_q, hist1_q, hist2_q);
`else
  localparam logic [11:0] START_OFS = 12'd1;
  assign bit_s = sync2_q;
`endif

  assign div_sel_s = (BitDiv < MIN_DIV_C) ? MIN_DIV_C : BitDiv;
  assign tick_s    = (cnt_q == 12'd0);

  // Line synchronizer and frame FSM state registers
  always_ff @(posedge CPUClk) begin
    if (Reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      div_q    <= 12'd0;
      cnt_q    <= 12'd0;
      par_en_q <= 1'b0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      perr_q   <= 1'b0;
    end else begin
      sync1_q  <= SLBit;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      armed_q  <= armed_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
    end
  end

  // Frame FSM next-state and bit sampling
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    commit_s = 1'b0;
    ferr_s   = 1'b0;
    if (!Enable) begin
      state_d = S_IDLE;
      armed_d = armed_q | sync2_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q && !sync2_q) begin
            div_d    = div_sel_s;
            par_en_d = ParEn;
            cnt_d    = (div_sel_s >> 1) - START_OFS;
            perr_d   = 1'b0;
            armed_d  = 1'b0;
            state_d  = S_START;
          end else begin
            armed_d = armed_q | sync2_q;
          end
        end
        S_START: begin
          if (!tick_s) begin
            cnt_d = cnt_q - 12'd1;
          end else if (!bit_s) begin
            cnt_d   = div_q - 12'd1;
            idx_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (!tick_s) begin
            cnt_d = cnt_q - 12'd1;
          end else begin
            cnt_d   = div_q - 12'd1;
            shift_d = {bit_s, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_PARITY: begin
          if (!tick_s) begin
            cnt_d = cnt_q - 12'd1;
          end else begin
            cnt_d   = div_q - 12'd1;
            perr_d  = even_par_err(shift_q, bit_s);
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (!tick_s) begin
            cnt_d = cnt_q - 12'd1;
          end else begin
            ferr_s   = ~bit_s;
            commit_s = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Holding buffer: commit, CPU read and overrun bookkeeping
  always_ff @(posedge CPUClk) begin
    if (Reset) begin
      rx_data_q <= 8'd0;
      av_q      <= 1'b0;
      cp_q      <= 1'b0;
      ov_q      <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      cp_q <= commit_s;
      if (commit_s) begin
        if (!av_q || cpu.Rd) begin
          rx_data_q <= shift_q;
          fe_q      <= ferr_s;
          pe_q      <= perr_q;
          av_q      <= 1'b1;
          if (av_q) begin
            ov_q <= 1'b0;
          end
        end else begin
          ov_q <= 1'b1;
        end
      end else if (cpu.Rd && av_q) begin
        av_q <= 1'b0;
        fe_q <= 1'b0;
        pe_q <= 1'b0;
        ov_q <= 1'b0;
      end
    end
  end

  assign cpu.RxData = rx_data_q;
  assign cpu.AV     = av_q;
  assign cpu.CP     = cp_q;
  assign cpu.OV     = ov_q;
  assign cpu.FE     = fe_q;
  assign cpu.PE     = pe_q;
endmodule

// File: tb/tb_usart_rx_deframer.sv
// Self-checking bench for usart_rx_deframer (default build): directed and
// randomized frames compared against a buffer-level reference model.
module tb_usart_rx_deframer;
  logic        CPUClk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [11:0] BitDiv;
  logic        ParEn;
  logic        SLBit;

  usart_rx_deframer_if bus ();

  usart_rx_deframer #(.MIN_DIV(4)) dut (
    .CPUClk (CPUClk),
    .Reset  (Reset),
    .Enable (Enable),
    .BitDiv (BitDiv),
    .ParEn  (ParEn),
    .SLBit  (SLBit),
    .cpu    (bus)
  );

  always #5 CPUClk = ~CPUClk;

  int n_checks = 0;
  int n_fail   = 0;
  int cp_cnt   = 0;

  always @(negedge CPUClk) begin
    if (bus.CP === 1'b1) cp_cnt++;
  end

  // Reference model of the CPU-visible buffer
  logic [7:0] m_data;
  logic       m_av, m_fe, m_pe, m_ov;
  int         m_cp;

  task automatic m_reset();
    m_data = 8'h00; m_av = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic m_commit(input logic [7:0] d, input logic fe, input logic pe, input logic rd);
    m_cp++;
    if (!m_av || rd) begin
      if (m_av) m_ov = 1'b0;
      m_data = d; m_fe = fe; m_pe = pe; m_av = 1'b1;
    end else begin
      m_ov = 1'b1;
    end
  endtask

  task automatic m_read();
    if (m_av) begin
      m_av = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cp"}, 32'(cp_cnt), 32'(m_cp));
    check({tag, "_data"}, {24'd0, bus.RxData}, {24'd0, m_data});
    check({tag, "_av"}, {31'd0, bus.AV}, {31'd0, m_av});
    check({tag, "_fe"}, {31'd0, bus.FE}, {31'd0, m_fe});
    check({tag, "_pe"}, {31'd0, bus.PE}, {31'd0, m_pe});
    check({tag, "_ov"}, {31'd0, bus.OV}, {31'd0, m_ov});
  endtask

  task automatic idle(input int n);
    SLBit = 1'b1;
    repeat (n) @(negedge CPUClk);
  endtask

  task automatic do_read();
    bus.Rd = 1'b1;
    @(negedge CPUClk);
    bus.Rd = 1'b0;
    m_read();
    @(negedge CPUClk);
  endtask

  // Drives one frame starting at the current negedge; optionally disturbs
  // BitDiv/ParEn after the start bit to show they are latched.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pval,
                            input logic stop, input int bitdiv, input logic scramble);
    int div;
    div    = (bitdiv < 4) ? 4 : bitdiv;
    BitDiv = 12'(bitdiv);
    ParEn  = pen;
    SLBit  = 1'b0;
    repeat (div) @(negedge CPUClk);
    if (scramble) begin
      BitDiv = 12'($urandom_range(4, 40));
      ParEn  = ~pen;
    end
    for (int i = 0; i < 8; i++) begin
      SLBit = d[i];
      repeat (div) @(negedge CPUClk);
    end
    if (pen) begin
      SLBit = pval;
      repeat (div) @(negedge CPUClk);
    end
    SLBit = stop;
    repeat (div) @(negedge CPUClk);
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] d, input logic pen,
                           input logic pval, input logic stop, input int bitdiv);
    send_frame(d, pen, pval, stop, bitdiv, 1'b1);
    m_commit(d, ~stop, pen ? ((^d) ^ pval) : 1'b0, 1'b0);
    idle(4);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] rd_b;
    logic       rp, rv, rs;
    int         rdiv;

    m_cp = 0;
    m_reset();
    Reset = 1'b1; Enable = 1'b1; SLBit = 1'b1; BitDiv = 12'd8; ParEn = 1'b0; bus.Rd = 1'b0;
    repeat (3) @(negedge CPUClk);
    check_all("reset");
    check("reset_cp_low", {31'd0, bus.CP}, 32'd0);
    Reset = 1'b0;
    idle(4);

    // Basic 8N1 frame and read-out
    frame_chk("a5", 8'hA5, 1'b0, 1'b0, 1'b1, 8);
    do_read();
    check("a5_read_av", {31'd0, bus.AV}, 32'd0);

    // Even parity good then bad
    frame_chk("3c_p0", 8'h3C, 1'b1, 1'b0, 1'b1, 16);
    do_read();
    frame_chk("3c_p1", 8'h3C, 1'b1, 1'b1, 1'b1, 16);
    do_read();

    // Framing error followed by a long break: no retrigger until line high
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8, 1'b0);
    m_commit(8'h55, 1'b1, 1'b0, 1'b0);
    repeat (40 * 8) @(negedge CPUClk);
    check_all("break_55");
    do_read();
    idle(4);
    frame_chk("after_break", 8'h01, 1'b0, 1'b0, 1'b1, 8);
    do_read();

    // Overrun, then read on the commit cycle of the next frame
    frame_chk("ov_11", 8'h11, 1'b0, 1'b0, 1'b1, 8);
    frame_chk("ov_22", 8'h22, 1'b0, 1'b0, 1'b1, 8);
    fork
      send_frame(8'h33, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      begin
        repeat (4 + 2 + 9 * 8) @(negedge CPUClk);
        bus.Rd = 1'b1;
        @(negedge CPUClk);
        bus.Rd = 1'b0;
      end
    join
    m_commit(8'h33, 1'b0, 1'b0, 1'b1);
    idle(4);
    check_all("rd_on_commit");

    // Short glitch on the idle line must not produce a frame
    BitDiv = 12'd8;
    SLBit  = 1'b0;
    repeat (2) @(negedge CPUClk);
    idle(30);
    check_all("glitch");

    // Enable dropped mid-frame: frame discarded, buffer untouched
    fork
      send_frame(8'h77, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      begin
        repeat (4 * 8) @(negedge CPUClk);
        Enable = 1'b0;
      end
    join
    idle(4);
    Enable = 1'b1;
    idle(4);
    check_all("enable_drop");

    // Reset while in the data bits
    SLBit = 1'b0;
    repeat (4 * 8) @(negedge CPUClk);
    SLBit = 1'b1;
    Reset = 1'b1;
    @(negedge CPUClk);
    m_reset();
    check_all("mid_reset");
    check("mid_reset_cp", {31'd0, bus.CP}, 32'd0);
    Reset = 1'b0;
    idle(4);
    frame_chk("c3", 8'hC3, 1'b0, 1'b0, 1'b1, 8);
    do_read();

    // BitDiv below MIN_DIV is clamped
    frame_chk("clamp", 8'h9E, 1'b0, 1'b0, 1'b1, 2);
    do_read();

    // Randomized frames with random reads
    for (int k = 0; k < 10; k++) begin
      rd_b = 8'($urandom_range(0, 255));
      rp   = 1'($urandom_range(0, 1));
      rv   = 1'($urandom_range(0, 1));
      rs   = ($urandom_range(0, 3) != 0);
      rdiv = $urandom_range(4, 14);
      frame_chk($sformatf("rnd%0d", k), rd_b, rp, rv, rs, rdiv);
      if ($urandom_range(0, 2) != 0) do_read();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/usart_rx_deframer.md
# usart_rx_deframer

Serial receive front-end of the USART: consumes the asynchronous serial line (SLBit) driven by a peer USART, recovers 8N1 / 8E1 frames at a CPU-programmed bit period, and presents each byte to the CPU side through a one-entry holding buffer with CP/OV/AV/FE/PE-style status. It sits directly downstream of the line that the USART transmitter drives, and upstream of the CPU receive path (Rec access).

## Interface
Parameters:
- MIN_DIV, 4, smallest honoured bit period in clocks; smaller BitDiv values are clamped to it.

Ports:
- CPUClk  in  1  sole clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- Enable  in  1  receiver enable; low forces the FSM to IDLE.
- BitDiv  in  12  clocks per serial bit; sampled at start-bit detection, held for the whole frame.
- ParEn  in  1  1 = even parity bit expected after the data bits; sampled at start-bit detection.
- SLBit  in  1  serial line, idle high, LSB first.
- Rd  in  1  CPU read strobe (one cycle); consumes the buffered byte.
- RxData  out  8  buffered byte.
- AV  out  1  buffer holds an unread byte.
- CP  out  1  one-cycle pulse: frame completed and committed.
- OV  out  1  sticky: a frame completed while the buffer was full and was dropped.
- FE  out  1  buffered byte had stop bit = 0.
- PE  out  1  buffered byte failed even parity (always 0 when ParEn = 0).

## Operation
- SLBit passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
- Armed flag: set when synchronized line = 1 in IDLE; start detection requires armed = 1 (prevents retrigger on a held-low line / break).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: armed and line = 0 -> latch div = max(BitDiv, MIN_DIV), latch ParEn, load counter = div/2 - 1 (integer floor), clear armed, go START.
  - START: counter reaches 0 -> sample; 0 -> counter = div-1, bit index 0, go DATA; 1 -> false start, go IDLE.
  - DATA: each counter expiry samples one bit into shift register LSB first, reloads counter = div-1; after bit 7 go PARITY if ParEn else STOP.
  - PARITY: sample p; perr = ^data ^ p.
  - STOP: sample; ferr = (sample == 0). Commit, go IDLE.
- Commit: buffer empty or Rd in the same cycle -> RxData <= data, FE <= ferr, PE <= perr, AV <= 1. Buffer full and no Rd -> frame dropped, OV <= 1, RxData/FE/PE unchanged. CP pulses in both cases.
- Rd with AV = 1 and no commit: AV, FE, PE, OV cleared. Rd with AV = 0: no effect.
- Rd and commit in the same cycle with AV = 1: old byte consumed, new byte loaded, AV stays 1, OV cleared (not set).
- Enable low: FSM to IDLE, partial frame discarded, no CP; buffer and flags untouched.

## Timing
- Reset values: RxData = 0, AV = 0, CP = 0, OV = 0, FE = 0, PE = 0, FSM = IDLE, armed = 0, sync flops = 1.
- Synchronizer latency 2 clocks; first sample point lands div/2 clocks after the synchronized falling edge, then every div clocks.
- CP, AV, FE, PE, OV update on the clock edge after the stop-bit sample cycle.
- Frame length: (10 + ParEn) x div clocks; a new start bit is accepted as soon as the line is seen high after the stop sample.
- Changes to BitDiv/ParEn mid-frame have no effect on that frame.
- Reset mid-frame: everything returns to reset values on the next edge; no CP.

## Configuration
- USART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of samples taken at sample point -1, 0, +1 clocks; false-start check uses the same vote.
- Not defined: single sample at the sample point; no extra registers.

## Test plan
- BitDiv = 8, ParEn = 0, send 0xA5 with stop = 1 -> one CP pulse, RxData = 0xA5, AV = 1, FE = PE = OV = 0; Rd -> AV = 0.
- BitDiv = 16, ParEn = 1, send 0x3C with parity 0, then 0x3C with parity 1 (reading between) -> PE = 0, then PE = 1, RxData = 0x3C both times.
- Send 0x55 with stop = 0, line held low 40 bit times, then high and send 0x01 -> first byte FE = 1, no second start until line high, second byte 0x01 FE = 0.
- Two frames 0x11, 0x22 without Rd -> RxData = 0x11, AV = 1, OV = 1, two CP pulses; Rd on the commit cycle of 0x22 in a separate run -> RxData = 0x22, OV = 0.
- 2-clock low glitch on idle line with BitDiv = 8 -> no CP, FSM back to IDLE; Enable dropped mid-frame -> no CP, AV unchanged.
- Reset asserted during DATA of a frame -> all outputs zero next cycle; following clean frame 0xC3 received correctly.
